// File: rtl/uart_pkg.sv
// Shared UART definitions: default divisor widths, the divisor struct and a
// helper that rounds clk/(baud*os) to an integer.fraction divisor.
package uart_pkg;

  localparam int UART_DIV_INT_W  = 16;
  localparam int UART_DIV_FRAC_W = 4;
  localparam int UART_OVERSAMPLE = 16;

  typedef struct packed {
    logic [UART_DIV_INT_W-1:0]  div_int;
    logic [UART_DIV_FRAC_W-1:0] div_frac;
  } baud_div_t;

  // Rounded to the nearest 1/2^UART_DIV_FRAC_W of a clock.
  function automatic baud_div_t calc_baud_div(input longint unsigned clk_freq,
                                              input longint unsigned baud,
                                              input longint unsigned os);
    longint unsigned den;
    longint unsigned q_fx;
    baud_div_t       r;
    den       = baud * os;
    q_fx      = ((clk_freq << UART_DIV_FRAC_W) + (den >> 1)) / den;
    r.div_int  = q_fx[UART_DIV_FRAC_W +: UART_DIV_INT_W];
    r.div_frac = q_fx[UART_DIV_FRAC_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/uart_frac_accum.sv
// Fractional phase accumulator: carry flags the period whose accumulation
// crosses a whole clock, so that period is one cycle longer.
module uart_frac_accum
  import uart_pkg::*;
#(
  parameter int FRAC_W = UART_DIV_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              clear,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W-1:0] acc_d;
  logic [FRAC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, frac};
    carry = sum[FRAC_W];
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = sum[FRAC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud generator: oversample tick at clk/(div_int + div_frac/2^F),
// plus mid-bit and bit ticks, with shadowed divisor and phase resync.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int DIV_INT_W    = UART_DIV_INT_W,
  parameter int DIV_FRAC_W   = UART_DIV_FRAC_W,
  parameter int OVERSAMPLE   = UART_OVERSAMPLE,
  parameter int RST_DIV_INT  = 27,
  parameter int RST_DIV_FRAC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  input  logic                  div_load,
  input  logic                  sync,
  output logic                  os_tick,
  output logic                  mid_tick,
  output logic                  bit_tick,
  output logic                  div_pending
);

  localparam int CNT_W = DIV_INT_W + 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]       OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]       OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [DIV_INT_W-1:0]  RST_INT  = DIV_INT_W'(RST_DIV_INT);
  localparam logic [DIV_FRAC_W-1:0] RST_FRAC = DIV_FRAC_W'(RST_DIV_FRAC);

  logic [DIV_INT_W-1:0]  act_int_q, act_int_d;
  logic [DIV_FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_INT_W-1:0]  shd_int_q, shd_int_d;
  logic [DIV_FRAC_W-1:0] shd_frac_q, shd_frac_d;
  logic                  pending_q, pending_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
  logic                  os_tick_q, os_tick_d;
  logic                  mid_tick_q, mid_tick_d;
  logic                  bit_tick_q, bit_tick_d;

  logic [DIV_INT_W-1:0]  act_int_eff;
  logic [CNT_W-1:0]      cur_period;
  logic                  carry;
  logic                  wrap;
  logic                  tick;
  logic                  apply;

  uart_frac_accum #(
    .FRAC_W (DIV_FRAC_W)
  ) u_frac_accum (
    .clk   (clk),
    .rst   (rst),
    .step  (tick),
    .clear (sync),
    .frac  (act_frac_q),
    .carry (carry)
  );

  always_comb begin
    act_int_eff = (act_int_q == '0) ? DIV_INT_W'(1) : act_int_q;
    cur_period  = {1'b0, act_int_eff} + CNT_W'(carry);
    // >= rather than == keeps a divisor swapped in while idle from overshooting.
    wrap        = (cnt_q >= cur_period - CNT_W'(1));
    tick        = en & wrap & ~sync;
    apply       = 1'b0;

    cnt_d      = cnt_q;
    os_cnt_d   = os_cnt_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    pending_d  = pending_q;

    if (div_load) begin
      shd_int_d  = div_int;
      shd_frac_d = div_frac;
    end

    if (sync) begin
      cnt_d     = '0;
      os_cnt_d  = '0;
      pending_d = 1'b0;
      if (div_load) begin
        act_int_d  = div_int;
        act_frac_d = div_frac;
      end else if (pending_q) begin
        act_int_d  = shd_int_q;
        act_frac_d = shd_frac_q;
      end
    end else begin
      if (en) begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      end
      if (tick) begin
        os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
      end
      apply = pending_q & (tick | ~en);
      if (apply) begin
        act_int_d  = shd_int_q;
        act_frac_d = shd_frac_q;
        pending_d  = 1'b0;
      end
      if (div_load) begin
        pending_d = 1'b1;
      end
    end

    os_tick_d  = tick;
    mid_tick_d = tick & (os_cnt_q == OS_MID);
    bit_tick_d = tick & (os_cnt_q == OS_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_int_q  <= RST_INT;
      act_frac_q <= RST_FRAC;
      shd_int_q  <= RST_INT;
      shd_frac_q <= RST_FRAC;
      pending_q  <= 1'b0;
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      os_tick_q  <= os_tick_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  assign os_tick     = os_tick_q;
  assign mid_tick    = mid_tick_q;
  assign bit_tick    = bit_tick_q;
  assign div_pending = pending_q;

endmodule
